// File: rtl/alu_share_arb.sv
// Two-requester round-robin front end for a single shared 32-bit ALU.
// Each result sits in one registered response slot tagged with the requester id.
module alu_share_arb #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [XLEN-1:0]  req0_a,
   input  logic [XLEN-1:0]  req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [XLEN-1:0]  req1_a,
   input  logic [XLEN-1:0]  req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [XLEN-1:0]  rsp_data,
   output logic             rsp_err,
   output logic [CNT_W-1:0] done_cnt
);

   typedef enum logic {
      EMPTY,
      FULL
   } state_e;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_XOR  = 4'd2,
      OP_OR   = 4'd3,
      OP_AND  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_SLT  = 4'd8,
      OP_SLTU = 4'd9
   } alu_op_e;

   state_e          state;
   logic            lg;
   logic            slot_free;
   logic            gnt_vld;
   logic            gnt_id;
   logic [3:0]      sel_op;
   logic [XLEN-1:0] sel_a;
   logic [XLEN-1:0] sel_b;
   logic [4:0]      shamt;
   logic [XLEN-1:0] alu_res;
   logic            alu_err;

   assign rsp_valid = (state == FULL);
   assign slot_free = !rsp_valid || rsp_ready;

   // lg names the last winner, so on a conflict the other requester goes next
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = 1'b0;
      if (slot_free) begin
         if (req0_valid && req1_valid) begin
            gnt_vld = 1'b1;
            gnt_id  = ~lg;
         end else if (req0_valid) begin
            gnt_vld = 1'b1;
         end else if (req1_valid) begin
            gnt_vld = 1'b1;
            gnt_id  = 1'b1;
         end
      end
   end

   assign req0_ready = gnt_vld && !gnt_id;
   assign req1_ready = gnt_vld &&  gnt_id;

   always_comb begin
      sel_op = req0_op;
      sel_a  = req0_a;
      sel_b  = req0_b;
      if (gnt_id) begin
         sel_op = req1_op;
         sel_a  = req1_a;
         sel_b  = req1_b;
      end
   end

   assign shamt = sel_b[4:0];

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (alu_op_e'(sel_op))
         OP_ADD:  alu_res = sel_a + sel_b;
         OP_SUB:  alu_res = sel_a - sel_b;
         OP_XOR:  alu_res = sel_a ^ sel_b;
         OP_OR:   alu_res = sel_a | sel_b;
         OP_AND:  alu_res = sel_a & sel_b;
         OP_SLL:  alu_res = sel_a << shamt;
         OP_SRL:  alu_res = sel_a >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(sel_a) >>> shamt);
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(sel_a) < $signed(sel_b)};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, sel_a < sel_b};
         default: begin
            alu_res = '0;
            alu_err = 1'b1;
         end
      endcase
   end

   // Drain and reload may coincide, keeping one result per cycle under contention
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         lg       <= 1'b1;
         rsp_id   <= 1'b0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
         done_cnt <= '0;
      end else begin
         if (rsp_valid && rsp_ready) begin
            done_cnt <= done_cnt + 1'b1;
         end
         if (gnt_vld) begin
            state    <= FULL;
            lg       <= gnt_id;
            rsp_id   <= gnt_id;
            rsp_data <= alu_res;
            rsp_err  <= alu_err;
         end else if (rsp_ready) begin
            state    <= EMPTY;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: vector table, arbitration model
// with a response scoreboard, and hand-written backpressure/reset sequences.
module tb_alu_share_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [3:0]  req0_op = '0, req1_op = '0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err;
   logic [31:0] rsp_data;
   logic [15:0] done_cnt;

   alu_share_arb #(.XLEN(32), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        err;
   } vec_t;

   typedef struct {
      logic        id;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   vec_t        tbl[12];
   rsp_t        q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic        m_full = 1'b0;
   logic        m_lg = 1'b1;
   logic [15:0] m_cnt = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [4:0]  sh;
      logic [31:0] r;
      sh = b[4:0];
      r  = '0;
      case (op)
         4'd0: r = a + b;
         4'd1: r = a + ~b + 32'd1;
         4'd2: r = (a | b) & ~(a & b);
         4'd3: r = a | b;
         4'd4: r = a & b;
         4'd5: r = a << sh;
         4'd6: r = a >> sh;
         4'd7: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
         4'd8: r = {31'b0, (a[31] != b[31]) ? a[31] : (a < b)};
         4'd9: r = {31'b0, a < b};
         default: return {1'b1, 32'h0};
      endcase
      return {1'b0, r};
   endfunction

   // Arbitration/response model; pushes expected results on every accept
   always @(negedge clk) begin
      logic slot, g0, g1;
      logic [32:0] r;
      if (rst) begin
         m_full = 1'b0;
         m_lg   = 1'b1;
         m_cnt  = '0;
         q.delete();
      end else begin
         slot = !m_full || rsp_ready;
         g0 = slot && req0_valid && (!req1_valid || m_lg);
         g1 = slot && req1_valid && (!req0_valid || !m_lg);
         chk("req0_ready", 32'(req0_ready), 32'(g0));
         chk("req1_ready", 32'(req1_ready), 32'(g1));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
         chk("done_cnt", 32'(done_cnt), 32'(m_cnt));
         if (m_full) begin
            if (q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL sb_underflow: response held but none expected at %0t", $time);
            end else begin
               chk("sb_id", 32'(rsp_id), 32'(q[0].id));
               chk("sb_data", rsp_data, q[0].data);
               chk("sb_err", 32'(rsp_err), 32'(q[0].err));
               if (rsp_ready) void'(q.pop_front());
            end
            if (rsp_ready) m_cnt = m_cnt + 16'd1;
         end
         if (g0) begin
            r = ref_alu(req0_op, req0_a, req0_b);
            q.push_back('{id: 1'b0, data: r[31:0], err: r[32]});
            m_lg = 1'b0;
         end else if (g1) begin
            r = ref_alu(req1_op, req1_a, req1_b);
            q.push_back('{id: 1'b1, data: r[31:0], err: r[32]});
            m_lg = 1'b1;
         end
         if (g0 || g1) m_full = 1'b1;
         else if (rsp_ready) m_full = 1'b0;
      end
   end

   task automatic issue(input logic id, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      logic got;
      got = 1'b0;
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (id ? req1_ready : req0_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_vec++;
         n_err++;
         $display("FAIL issue_timeout: req%0d never accepted, ready=0 expected 1", id);
      end
      @(posedge clk);
      #1;
      if (id) req1_valid = 1'b0;
      else req0_valid = 1'b0;
   endtask

   logic [3:0] c0ops[4] = '{4'd0, 4'd2, 4'd4, 4'd6};
   logic [3:0] c1ops[4] = '{4'd1, 4'd3, 4'd5, 4'd9};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int i0, i1;
      logic a0, a1;
      tbl[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
      tbl[1]  = '{4'd5,  32'h8000_0000, 32'h0000_0021, 32'h0000_0000, 1'b0};
      tbl[2]  = '{4'd6,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b0};
      tbl[3]  = '{4'd7,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0};
      tbl[4]  = '{4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
      tbl[5]  = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
      tbl[6]  = '{4'd1,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0};
      tbl[7]  = '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
      tbl[8]  = '{4'd3,  32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b0};
      tbl[9]  = '{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
      tbl[10] = '{4'd12, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1};
      tbl[11] = '{4'd0,  32'h0000_0007, 32'h0000_0008, 32'h0000_000F, 1'b0};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_valid", 32'(rsp_valid), 32'h0);
      chk("rst_id", 32'(rsp_id), 32'h0);
      chk("rst_data", rsp_data, 32'h0);
      chk("rst_err", 32'(rsp_err), 32'h0);
      chk("rst_cnt", 32'(done_cnt), 32'h0);

      for (int k = 0; k < 12; k++) begin
         issue(1'b0, tbl[k].op, tbl[k].a, tbl[k].b);
         chk("tbl_valid", 32'(rsp_valid), 32'h1);
         chk("tbl_id", 32'(rsp_id), 32'h0);
         chk("tbl_data", rsp_data, tbl[k].exp);
         chk("tbl_err", 32'(rsp_err), 32'(tbl[k].err));
         if (k == 0) begin
            @(posedge clk);
            #1 chk("first_cnt", 32'(done_cnt), 32'h1);
         end
      end
      @(posedge clk);
      #1 chk("tbl_cnt", 32'(done_cnt), 32'd12);

      // Backpressure: held response stays put and blocks both requesters
      rsp_ready = 1'b0;
      issue(1'b0, 4'd0, 32'd10, 32'd20);
      req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'd50; req1_b = 32'd8;
      for (int c = 0; c < 3; c++) begin
         chk("bp_valid", 32'(rsp_valid), 32'h1);
         chk("bp_id", 32'(rsp_id), 32'h0);
         chk("bp_data", rsp_data, 32'd30);
         chk("bp_ready0", 32'(req0_ready), 32'h0);
         chk("bp_ready1", 32'(req1_ready), 32'h0);
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      #1 chk("bp_release", 32'(req1_ready), 32'h1);
      @(posedge clk);
      #1 req1_valid = 1'b0;
      chk("bp_next_id", 32'(rsp_id), 32'h1);
      chk("bp_next_data", rsp_data, 32'd42);

      // Reset while a response is held: discard it and restore the pointer
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      issue(1'b0, 4'd4, 32'h0000_00FF, 32'h0000_000F);
      chk("mid_valid", 32'(rsp_valid), 32'h1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mid_valid_clr", 32'(rsp_valid), 32'h0);
      chk("mid_cnt_clr", 32'(done_cnt), 32'h0);

      // Contention: alternating grants starting with requester 0
      rsp_ready = 1'b1;
      i0 = 0; i1 = 0;
      req0_valid = 1'b1; req0_op = c0ops[0]; req0_a = 32'h0000_1000; req0_b = 32'd3;
      req1_valid = 1'b1; req1_op = c1ops[0]; req1_a = 32'h8000_2000; req1_b = 32'd7;
      #1;
      chk("cont_first0", 32'(req0_ready), 32'h1);
      chk("cont_first1", 32'(req1_ready), 32'h0);
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         a0 = req0_valid && req0_ready;
         a1 = req1_valid && req1_ready;
         chk("cont_acc", 32'(a0 | a1), 32'h1);
         chk("cont_id", 32'(a1), 32'(s % 2));
         @(posedge clk);
         #1;
         if (a0) begin
            i0++;
            if (i0 == 4) req0_valid = 1'b0;
            else begin
               req0_op = c0ops[i0]; req0_a = 32'h0000_1000 + 32'(i0 * 17); req0_b = 32'(i0 + 3);
            end
         end
         if (a1) begin
            i1++;
            if (i1 == 4) req1_valid = 1'b0;
            else begin
               req1_op = c1ops[i1]; req1_a = 32'h8000_2000 - 32'(i1 * 29); req1_b = 32'(i1 + 7);
            end
         end
      end
      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 32'(q.size()), 32'h0);
      chk("cont_cnt", 32'(done_cnt), 32'd8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one 32-bit integer ALU datapath between two requesters (e.g. two issue slots).
- Arbitrates between them round-robin and evaluates the 10-entry alu_code function set.
- Returns each result through a single registered response channel, tagged with the requester id and using valid/ready handshakes.
- Sits between the issue logic and writeback; it is the only sequencer for the ALU.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  4  alu_code for requester 0
- req0_a  in  32  operand 1 for requester 0
- req0_b  in  32  operand 2 for requester 0
- req1_valid  in  1  requester 1 has an operation
- req1_ready  out  1  requester 1 operation accepted this cycle
- req1_op  in  4  alu_code for requester 1
- req1_a  in  32  operand 1 for requester 1
- req1_b  in  32  operand 2 for requester 1
- rsp_valid  out  1  response holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  requester that issued this result
- rsp_data  out  32  result
- rsp_err  out  1  op code was illegal (10..15)
- done_cnt  out  CNT_W  number of responses consumed, wraps

Behaviour:
- Reset: clocked on clk with rst synchronous and active-high.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, done_cnt=0.
  - Last-grant pointer lg=1, so requester 0 wins the first conflict.
  - Reset mid-transaction discards the held response; nothing is replayed.
- States:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1, output register holding a result).
- Slot free: slot_free = !rsp_valid || rsp_ready. A response drained and a new one loaded in the same cycle is legal, giving a full-throughput pipeline.
- Grant: combinational, evaluated only when slot_free.
  - Only one valid: grant it.
  - Both valid: grant 0 if lg==1, else grant 1.
  - reqN_ready = slot_free && grant==N. At most one ready is high per cycle; ready never depends on rsp_valid of the same port.
- Accept: on a clock edge with reqN_valid && reqN_ready:
  - The output register loads the result, rsp_id=N, rsp_err, rsp_valid=1.
  - lg<=N.
  - Latency is exactly 1 cycle from acceptance to rsp_valid.
- Drain without accept: rsp_valid && rsp_ready with no new accept gives rsp_valid<=0.
- Hold: while rsp_valid && !rsp_ready, rsp_id, rsp_data and rsp_err hold stable and both reqN_ready are 0.
- done_cnt: increments on every rsp_valid && rsp_ready edge; wraps modulo 2^CNT_W.
- Function on (a, b); shift amount is b[4:0]:
  - 0 add: a+b, mod 2^32.
  - 1 sub: a-b, mod 2^32.
  - 2 xor.
  - 3 or.
  - 4 and.
  - 5 sll.
  - 6 srl: zero fill.
  - 7 sra: sign fill.
  - 8 slt: signed compare, result {31'b0, a<b}.
  - 9 sltu: unsigned compare, result {31'b0, a<b}.
  - 10..15: data=0, rsp_err=1. The op is still accepted and counted like a legal one.
- Fairness: with both requesters continuously valid and rsp_ready=1, grants alternate 0,1,0,1…; no requester waits more than one granted slot.
- Requester-side rules: requesters hold op/a/b stable while valid && !ready. The block samples operands only on the accept edge.

Test Plan:
- Single op, then reset-value check:
  - After reset, all outputs are 0.
  - req0 add a=32'hFFFF_FFFF, b=1, rsp_ready=1 → next cycle rsp_valid=1, rsp_id=0, rsp_data=0, rsp_err=0; done_cnt=1 after the drain edge.
- Op sweep:
  - a=32'h8000_0000, b=32'h0000_0021, ops 5/6/7 → 0, 32'h4000_0000, 32'hC000_0000 (shift=1).
  - slt a=-1, b=1 → 1; sltu on the same operands → 0; sub 3-5 → 32'hFFFF_FFFE.
- Contention:
  - Both requesters valid every cycle with distinct ops, rsp_ready=1 → rsp_id sequence 0,1,0,1 and one response per cycle.
  - Each requester's results return in its own issue order.
- Backpressure:
  - rsp_ready=0 for 3 cycles with rsp_valid=1 → rsp fields stable and both reqN_ready=0.
  - Raising rsp_ready with req1 valid → req1 accepted on the same edge and its result appears the next cycle.
- Illegal op: op=4'd12 → rsp_err=1, rsp_data=0, done_cnt increments on drain; the next legal op gives rsp_err=0.
- Reset mid-operation: assert rst while rsp_valid=1 and rsp_ready=0 → next cycle rsp_valid=0, done_cnt=0, and the next conflict grants requester 0 first.
